// File: rtl/floppy_pkg.sv
// Shared constants, state type and size-code helper for the floppy ID field generator.
package floppy_pkg;

  localparam logic [15:0] CRC_POLY   = 16'h1021;
  // CRC-CCITT state after the A1 A1 A1 FE address mark, seeded with FFFF
  localparam logic [15:0] CRC_PRESET = 16'hB230;
  localparam int unsigned ID_LEN     = 6;
  localparam logic [2:0]  IDX_LAST   = 3'(ID_LEN - 1);
  localparam logic [1:0]  SIZE_DFLT  = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } id_state_t;

  // Map bytes-per-sector to the ID size code. 1024 does not fit in the
  // 10-bit length field and arrives as 0, so 0 is treated as 1024.
  function automatic logic [1:0] size_code(input logic [9:0] len, input logic [1:0] dflt);
    logic [1:0] code;
    case (len)
      10'd128: code = 2'd0;
      10'd256: code = 2'd1;
      10'd512: code = 2'd2;
      10'd0:   code = 2'd3;
      default: code = dflt;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One byte of MSB-first CRC-CCITT, all eight bit-steps in a single cycle.
module crc16_ccitt_byte
  import floppy_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // Shift the data byte through the CRC register, MSB first
  always_comb begin
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/floppy_id_field.sv
// Builds the 6-byte sector ID field (track, side, sector, size, CRC hi/lo)
// from the drive model's header window, paced by the drive byte clock.
module floppy_id_field
  import floppy_pkg::*;
#(
  parameter logic [15:0] CRC_PRESET_P = CRC_PRESET,
  parameter logic [1:0]  SIZE_DFLT_P  = SIZE_DFLT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dclk_en,
  input  logic        ready,
  input  logic        sector_hdr,
  input  logic [6:0]  track,
  input  logic        side,
  input  logic [4:0]  sector,
  input  logic [9:0]  sector_len,
  output logic [7:0]  id_byte,
  output logic        id_valid,
  output logic        id_last,
  output logic        id_done,
  output logic [6:0]  id_track,
  output logic        id_side,
  output logic [4:0]  id_sector,
  output logic [1:0]  id_size,
  output logic [15:0] id_crc
);

  id_state_t   state;
  logic [2:0]  idx;
  logic [15:0] crc;
  logic        hdr_q;
  logic [6:0]  snap_track;
  logic        snap_side;
  logic [4:0]  snap_sector;
  logic [1:0]  snap_size;

  logic        hdr_rise;
  logic [7:0]  emit_byte;
  logic [15:0] crc_seed;
  logic [15:0] crc_next;

  assign hdr_rise = sector_hdr & ~hdr_q & ready;

  // Select the byte for the current slot; in IDLE it is byte 0 from live inputs
  always_comb begin
    emit_byte = {1'b0, snap_track};
    crc_seed  = crc;
    if (state == IDLE) begin
      emit_byte = {1'b0, track};
      crc_seed  = CRC_PRESET_P;
    end else begin
      case (idx)
        3'd1:    emit_byte = {7'b0, snap_side};
        3'd2:    emit_byte = {3'b0, snap_sector};
        3'd3:    emit_byte = {6'b0, snap_size};
        3'd4:    emit_byte = crc[15:8];
        3'd5:    emit_byte = crc[7:0];
        default: emit_byte = {1'b0, snap_track};
      endcase
    end
  end

  crc16_ccitt_byte u_crc (
    .crc_in  (crc_seed),
    .data    (emit_byte),
    .crc_out (crc_next)
  );

  // ID field sequencer: snapshot at header start, emit one byte per byte clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= 3'd0;
      crc         <= CRC_PRESET_P;
      hdr_q       <= 1'b0;
      snap_track  <= 7'd0;
      snap_side   <= 1'b0;
      snap_sector <= 5'd0;
      snap_size   <= 2'd0;
      id_byte     <= 8'd0;
      id_valid    <= 1'b0;
      id_last     <= 1'b0;
      id_done     <= 1'b0;
      id_track    <= 7'd0;
      id_side     <= 1'b0;
      id_sector   <= 5'd0;
      id_size     <= 2'd0;
      id_crc      <= 16'd0;
    end else begin
      id_valid <= 1'b0;
      id_last  <= 1'b0;
      id_done  <= 1'b0;
      if (dclk_en) begin
        hdr_q <= sector_hdr;
        case (state)
          IDLE: begin
            if (hdr_rise) begin
              snap_track  <= track;
              snap_side   <= side;
              snap_sector <= sector;
              snap_size   <= size_code(sector_len, SIZE_DFLT_P);
              id_byte     <= emit_byte;
              id_valid    <= 1'b1;
              crc         <= crc_next;
              idx         <= 3'd1;
              state       <= EMIT;
            end
          end
          EMIT: begin
            if (sector_hdr && ready) begin
              id_byte  <= emit_byte;
              id_valid <= 1'b1;
              if (idx <= 3'd3) begin
                crc <= crc_next;
              end
              if (idx == IDX_LAST) begin
                id_last   <= 1'b1;
                id_done   <= 1'b1;
                id_track  <= snap_track;
                id_side   <= snap_side;
                id_sector <= snap_sector;
                id_size   <= snap_size;
                id_crc    <= crc;
                idx       <= 3'd0;
                state     <= IDLE;
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              // header window closed or drive dropped ready: abandon the field
              idx   <= 3'd0;
              state <= IDLE;
            end
          end
          default: begin
            idx   <= 3'd0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_floppy_id_field.sv
// Self-checking bench for floppy_id_field: table of ID fields, hand-written
// corner sequences and randomized fields against a message-level CRC model.
module tb_floppy_id_field;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dclk_en = 1'b0;
  logic        ready = 1'b1;
  logic        sector_hdr = 1'b0;
  logic [6:0]  track = 7'd0;
  logic        side = 1'b0;
  logic [4:0]  sector = 5'd0;
  logic [9:0]  sector_len = 10'd0;
  logic [7:0]  id_byte;
  logic        id_valid, id_last, id_done;
  logic [6:0]  id_track;
  logic        id_side;
  logic [4:0]  id_sector;
  logic [1:0]  id_size;
  logic [15:0] id_crc;

  floppy_id_field dut (
    .clk(clk), .reset_n(reset_n), .dclk_en(dclk_en), .ready(ready),
    .sector_hdr(sector_hdr), .track(track), .side(side), .sector(sector),
    .sector_len(sector_len), .id_byte(id_byte), .id_valid(id_valid),
    .id_last(id_last), .id_done(id_done), .id_track(id_track),
    .id_side(id_side), .id_sector(id_sector), .id_size(id_size), .id_crc(id_crc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] got[$];
  bit         lastq[$];
  int         done_cnt = 0;

  // expected contents of the last-ID registers
  logic [6:0]  m_track = 7'd0;
  logic        m_side = 1'b0;
  logic [4:0]  m_sector = 5'd0;
  logic [1:0]  m_size = 2'd0;
  logic [15:0] m_crc = 16'd0;

  // collect emitted bytes and done strobes
  always @(negedge clk) begin
    if (id_valid) begin
      got.push_back(id_byte);
      lastq.push_back(id_last);
    end
    if (id_done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC over the whole address-mark message A1 A1 A1 FE + 4 body bytes, from FFFF
  function automatic logic [15:0] model_crc(input logic [31:0] body);
    logic [63:0] msg;
    logic [15:0] r;
    logic        fb;
    msg = {32'hA1A1A1FE, body};
    r = 16'hFFFF;
    for (int i = 63; i >= 0; i--) begin
      fb = r[15] ^ msg[i];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [1:0] model_size(input int len);
    if (len == 128) return 2'd0;
    if (len == 256) return 2'd1;
    if (len == 512) return 2'd2;
    if (len == 1024) return 2'd3;
    return 2'd2;
  endfunction

  task automatic byte_clk(input logic h, input logic r);
    @(negedge clk);
    sector_hdr = h;
    ready = r;
    dclk_en = 1'b1;
    @(negedge clk);
    dclk_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_trk"}, 32'(id_track), 32'(m_track));
    check({tag, "_side"}, 32'(id_side), 32'(m_side));
    check({tag, "_sec"}, 32'(id_sector), 32'(m_sector));
    check({tag, "_size"}, 32'(id_size), 32'(m_size));
    check({tag, "_crc"}, 32'(id_crc), 32'(m_crc));
  endtask

  // run one header window holding sector_hdr for n byte clocks, then check
  task automatic do_field(input string tag, input int trk, input int sd, input int sec,
                          input int len, input int n);
    logic [7:0]  exp[6];
    logic [15:0] c;
    int          nexp, d0, nlast;
    exp[0] = {1'b0, 7'(trk)};
    exp[1] = {7'b0, 1'(sd)};
    exp[2] = {3'b0, 5'(sec)};
    exp[3] = {6'b0, model_size(len)};
    c = model_crc({exp[0], exp[1], exp[2], exp[3]});
    exp[4] = c[15:8];
    exp[5] = c[7:0];
    got.delete();
    lastq.delete();
    d0 = done_cnt;
    track = 7'(trk); side = 1'(sd); sector = 5'(sec); sector_len = 10'(len);
    byte_clk(1'b0, 1'b1);
    for (int i = 0; i < n; i++) byte_clk(1'b1, 1'b1);
    byte_clk(1'b0, 1'b1);
    nexp = (n < 6) ? n : 6;
    check({tag, "_nbytes"}, 32'(got.size()), 32'(nexp));
    for (int i = 0; i < nexp; i++)
      if (i < got.size()) check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    nlast = 0;
    foreach (lastq[i]) if (lastq[i]) nlast++;
    if (n >= 6) begin
      m_track = 7'(trk); m_side = 1'(sd); m_sector = 5'(sec);
      m_size = model_size(len); m_crc = c;
      check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_last"}, 32'(nlast), 32'd1);
      if (got.size() == 6) check({tag, "_lastpos"}, 32'(lastq[5]), 32'd1);
    end else begin
      check({tag, "_done"}, 32'(done_cnt - d0), 32'd0);
      check({tag, "_last"}, 32'(nlast), 32'd0);
    end
    check_regs(tag);
  endtask

  typedef struct {
    int         trk;
    int         sd;
    int         sec;
    int         len;
    int         n;
    logic [7:0] exp_size;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0;
    vecs[0] = '{trk: 0,  sd: 0, sec: 1,  len: 512,  n: 6, exp_size: 8'h02};
    vecs[1] = '{trk: 5,  sd: 1, sec: 9,  len: 300,  n: 6, exp_size: 8'h02};
    vecs[2] = '{trk: 79, sd: 1, sec: 18, len: 1024, n: 6, exp_size: 8'h03};
    vecs[3] = '{trk: 3,  sd: 0, sec: 7,  len: 128,  n: 6, exp_size: 8'h00};
    vecs[4] = '{trk: 10, sd: 1, sec: 2,  len: 256,  n: 6, exp_size: 8'h01};
    vecs[5] = '{trk: 40, sd: 0, sec: 5,  len: 512,  n: 3, exp_size: 8'h02};
    vecs[6] = '{trk: 12, sd: 1, sec: 31, len: 128,  n: 8, exp_size: 8'h00};

    // reset state
    #12;
    check("rst_outs", {id_byte, id_valid, id_last, id_done, id_track, id_side,
                       id_sector, id_size, id_crc}, 32'd0);
    check("rst_crc_hi", 32'(id_crc), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // reference vector with a known CRC
    do_field("ref", 0, 0, 1, 512, 6);
    check("ref_crc_const", 32'(id_crc), 32'h0000CA6F);
    if (got.size() == 6) check("ref_b5_const", 32'(got[5]), 32'h6F);

    // idle: no header for 10000 byte clocks
    got.delete();
    d0 = done_cnt;
    sector_hdr = 1'b0; ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk); dclk_en = 1'b1;
      @(negedge clk); dclk_en = 1'b0;
    end
    check("idle_valid", 32'(got.size()), 32'd0);
    check("idle_done", 32'(done_cnt - d0), 32'd0);

    // table of fields
    for (int i = 0; i < 7; i++) begin
      do_field($sformatf("vec%0d", i), vecs[i].trk, vecs[i].sd, vecs[i].sec, vecs[i].len, vecs[i].n);
      if (got.size() > 3) check($sformatf("vec%0d_size", i), 32'(got[3]), 32'(vecs[i].exp_size));
    end

    // track steps after byte 1: emitted field keeps the snapshot
    got.delete();
    d0 = done_cnt;
    track = 7'd0; side = 1'b0; sector = 5'd1; sector_len = 10'd512;
    byte_clk(1'b0, 1'b1);
    byte_clk(1'b1, 1'b1);
    byte_clk(1'b1, 1'b1);
    track = 7'd1;
    for (int i = 0; i < 4; i++) byte_clk(1'b1, 1'b1);
    byte_clk(1'b0, 1'b1);
    check("step_nbytes", 32'(got.size()), 32'd6);
    if (got.size() > 0) check("step_b0", 32'(got[0]), 32'h00);
    check("step_done", 32'(done_cnt - d0), 32'd1);
    check("step_idtrk", 32'(id_track), 32'd0);
    check("step_crc", 32'(id_crc), 32'h0000CA6F);
    m_track = 7'd0; m_side = 1'b0; m_sector = 5'd1; m_size = 2'd2; m_crc = 16'hCA6F;

    // ready low at header rise, high mid-window: nothing until next window
    got.delete();
    d0 = done_cnt;
    track = 7'd20; sector = 5'd3;
    byte_clk(1'b0, 1'b1);
    byte_clk(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) byte_clk(1'b1, 1'b1);
    check("rdy_nbytes", 32'(got.size()), 32'd0);
    check("rdy_done", 32'(done_cnt - d0), 32'd0);
    check_regs("rdy");
    do_field("rdy_next", 20, 1, 3, 256, 6);

    // randomized fields, including aborted ones
    for (int k = 0; k < 25; k++) begin
      int len;
      case ($urandom_range(0, 4))
        0: len = 128;
        1: len = 256;
        2: len = 512;
        3: len = 1024;
        default: len = int'($urandom_range(1, 1023));
      endcase
      do_field($sformatf("rnd%0d", k), int'($urandom_range(0, 127)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 31)), len, int'($urandom_range(1, 8)));
    end

    // async reset in the middle of a field
    got.delete();
    d0 = done_cnt;
    track = 7'd33; sector = 5'd4; sector_len = 10'd512;
    byte_clk(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) byte_clk(1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_outs", {id_byte, id_valid, id_last, id_done, id_track, id_side,
                        id_sector, id_size}, 32'd0);
    check("arst_crc", 32'(id_crc), 32'd0);
    for (int i = 0; i < 3; i++) byte_clk(1'b1, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) byte_clk(1'b0, 1'b1);
    check("arst_nbytes", 32'(got.size()), 32'd3);
    check("arst_done", 32'(done_cnt - d0), 32'd0);
    m_track = 7'd0; m_side = 1'b0; m_sector = 5'd0; m_size = 2'd0; m_crc = 16'd0;
    check_regs("arst");
    do_field("post_rst", 2, 1, 9, 1024, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
